// File: rtl/ram_responder_pkg.sv
// ----------------------------------------------------------------------------
// ram_responder_pkg
//   Shared constants and types for the RAM responder: address/data widths,
//   the memory map (framebuffer size, program base / core reset PC), the
//   clear FSM state encoding and the read-data select codes used by the
//   registered output muxes.
// ----------------------------------------------------------------------------
package ram_responder_pkg;

  // Bus geometry
  localparam int RR_ADDR_W = 15;
  localparam int RR_DATA_W = 16;
  localparam int RR_DEPTH  = 32768;

  // Memory map: framebuffer at the bottom, program image above it.
  localparam int RR_FB_LINE_WORDS = 80;
  localparam int RR_FB_LINES      = 240;
  localparam int RR_FB_WORDS      = RR_FB_LINE_WORDS * RR_FB_LINES;
  localparam int RR_CORE_RESET_PC = 19216;
  localparam int RR_PROG_BASE     = RR_CORE_RESET_PC;

  // Clear FSM
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rr_state_e;

  // Where a registered read port takes its value from on the next cycle.
  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_FWD  = 2'd2
  } rr_rd_sel_e;

  // Unsigned "address < bound" that works for any integer bound.
  function automatic logic addr_below(input logic [RR_ADDR_W-1:0] addr,
                                      input int bound);
    return {{(32-RR_ADDR_W){1'b0}}, addr} < $unsigned(bound);
  endfunction

endpackage

// File: rtl/ram_responder_dp_ram.sv
// ----------------------------------------------------------------------------
// dp_ram_wf
//   Simple dual-port block RAM.
//   Port A : write port with a registered read-first output (old contents).
//   Port B : read-only port with a registered output.
//   No reset on the array or the output registers so the array maps onto
//   a plain block RAM; the wrapper decides when the outputs are meaningful.
// Ports
//   clk      : clock
//   a_we     : port A write enable
//   a_addr   : port A address
//   a_wdata  : port A write data
//   a_rdata  : port A registered read data (value before any same-cycle write)
//   b_addr   : port B address
//   b_rdata  : port B registered read data
// ----------------------------------------------------------------------------
module dp_ram_wf #(
  parameter int DEPTH  = 32768,
  parameter int DATA_W = 16,
  parameter int AW     = 15
) (
  input  logic              clk,
  input  logic              a_we,
  input  logic [AW-1:0]     a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [AW-1:0]     b_addr,
  output logic [DATA_W-1:0] b_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;

  always_ff @(posedge clk) begin
    if (a_we) begin
      r_mem[a_addr] <= a_wdata;
    end
    // Non-blocking reads see the pre-write contents: read-first behaviour.
    r_a_rdata <= r_mem[a_addr];
    r_b_rdata <= r_mem[b_addr];
  end

  assign a_rdata = r_a_rdata;
  assign b_rdata = r_b_rdata;

endmodule

// File: rtl/ram_responder.sv
// ----------------------------------------------------------------------------
// ram_responder
//   Memory-side responder for the core's RAM bus plus a read-only display
//   port. After reset it zero-fills the framebuffer [0, FB_WORDS) one word
//   per cycle while holding the core, then serves both ports with a fixed
//   one-cycle latency. Core writes at or above PROG_BASE are trapped when
//   protect_en is set. Words outside the framebuffer are never touched by
//   the clear, so a program image loaded into the RAM by the surrounding
//   flow survives reset.
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   ram_address    : core word address
//   data_to_ram    : core write data
//   web            : core write enable (1 = write)
//   data_from_ram  : core read data, one cycle after the request
//   vga_address    : display read address
//   vga_data       : display read data, one cycle after the request
//   protect_en     : block core writes at addresses >= PROG_BASE
//   core_hold      : to the core's debug_core input, 1 while clearing
//   busy_clear     : 1 while clearing
//   prot_fault     : sticky, set by a blocked write, cleared by rst
//   fault_addr     : address of the first blocked write since reset
// ----------------------------------------------------------------------------
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int DEPTH     = RR_DEPTH,
  parameter int FB_WORDS  = RR_FB_WORDS,
  parameter int PROG_BASE = RR_PROG_BASE,
  parameter int DATA_W    = RR_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RR_ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0]    data_to_ram,
  input  logic                 web,
  output logic [DATA_W-1:0]    data_from_ram,
  input  logic [RR_ADDR_W-1:0] vga_address,
  output logic [DATA_W-1:0]    vga_data,
  input  logic                 protect_en,
  output logic                 core_hold,
  output logic                 busy_clear,
  output logic                 prot_fault,
  output logic [RR_ADDR_W-1:0] fault_addr
);

  localparam logic [RR_ADDR_W-1:0] CLEAR_LAST = RR_ADDR_W'(FB_WORDS - 1);

  // --------------------------------------------------------------------------
  // Clear FSM
  // --------------------------------------------------------------------------
  rr_state_e            r_state;
  rr_state_e            w_state_next;
  logic [RR_ADDR_W-1:0] r_clear_ptr;
  logic [RR_ADDR_W-1:0] w_clear_ptr_next;
  logic                 w_clearing;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_CLEAR;
      r_clear_ptr <= '0;
    end else begin
      r_state     <= w_state_next;
      r_clear_ptr <= w_clear_ptr_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_clear_ptr_next = r_clear_ptr;
    w_clearing       = 1'b0;
    unique case (r_state)
      ST_CLEAR: begin
        w_clearing       = 1'b1;
        w_clear_ptr_next = r_clear_ptr + RR_ADDR_W'(1);
        // The last framebuffer word is written this cycle; RUN from the
        // next edge, giving exactly FB_WORDS cycles of clear.
        if (r_clear_ptr == CLEAR_LAST) begin
          w_state_next     = ST_RUN;
          w_clear_ptr_next = '0;
        end
      end
      ST_RUN: begin
        w_state_next = ST_RUN;
      end
      default: begin
        w_state_next     = ST_CLEAR;
        w_clear_ptr_next = '0;
      end
    endcase
  end

  assign core_hold  = w_clearing;
  assign busy_clear = w_clearing;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic w_run;          // serving the ports this cycle
  logic w_clear_wr;     // clear engine owns port A this cycle
  logic w_core_in_rng;
  logic w_vga_in_rng;
  logic w_in_prog;
  logic w_blocked;      // core write trapped by protection
  logic w_core_wr;      // core write that actually reaches the array
  logic w_vga_hit;      // display reads the word the core is writing

  // rst gates everything so nothing is written on the reset edge itself.
  assign w_run      = (r_state == ST_RUN) && !rst;
  assign w_clear_wr = (r_state == ST_CLEAR) && !rst;

  assign w_core_in_rng = addr_below(ram_address, DEPTH);
  assign w_vga_in_rng  = addr_below(vga_address, DEPTH);
  assign w_in_prog     = !addr_below(ram_address, PROG_BASE);

  // Protection is evaluated regardless of whether the address is backed.
  assign w_blocked = w_run && web && protect_en && w_in_prog;
  assign w_core_wr = w_run && web && !w_blocked && w_core_in_rng;
  assign w_vga_hit = w_core_wr && (vga_address == ram_address);

  // --------------------------------------------------------------------------
  // Backing store
  // --------------------------------------------------------------------------
  logic                 w_ram_a_we;
  logic [RR_ADDR_W-1:0] w_ram_a_addr;
  logic [DATA_W-1:0]    w_ram_a_wdata;
  logic [DATA_W-1:0]    w_ram_a_q;
  logic [DATA_W-1:0]    w_ram_b_q;

  always_comb begin
    w_ram_a_we    = w_core_wr;
    w_ram_a_addr  = ram_address;
    w_ram_a_wdata = data_to_ram;
    if (w_clear_wr) begin
      w_ram_a_we    = 1'b1;
      w_ram_a_addr  = r_clear_ptr;
      w_ram_a_wdata = '0;
    end
  end

  dp_ram_wf #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (RR_ADDR_W)
  ) u_ram (
    .clk     (clk),
    .a_we    (w_ram_a_we),
    .a_addr  (w_ram_a_addr),
    .a_wdata (w_ram_a_wdata),
    .a_rdata (w_ram_a_q),
    .b_addr  (vga_address),
    .b_rdata (w_ram_b_q)
  );

  // --------------------------------------------------------------------------
  // Registered output selection. The RAM output registers carry no reset,
  // so each port registers where its data comes from next cycle: zero
  // (reset, clear, unbacked address), the RAM, or the forwarded write data.
  // --------------------------------------------------------------------------
  rr_rd_sel_e        r_core_sel;
  rr_rd_sel_e        w_core_sel_next;
  rr_rd_sel_e        r_vga_sel;
  rr_rd_sel_e        w_vga_sel_next;
  logic [DATA_W-1:0] r_fwd_data;

  always_comb begin
    w_core_sel_next = SEL_ZERO;
    if (w_run) begin
      if (w_core_wr) begin
        w_core_sel_next = SEL_FWD;           // write-first on the core port
      end else if (w_core_in_rng) begin
        w_core_sel_next = SEL_RAM;           // read, or blocked write: old data
      end
    end
  end

  always_comb begin
    w_vga_sel_next = SEL_ZERO;
    if (w_run && w_vga_in_rng) begin
      w_vga_sel_next = w_vga_hit ? SEL_FWD : SEL_RAM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_core_sel <= SEL_ZERO;
      r_vga_sel  <= SEL_ZERO;
      r_fwd_data <= '0;
    end else begin
      r_core_sel <= w_core_sel_next;
      r_vga_sel  <= w_vga_sel_next;
      r_fwd_data <= data_to_ram;
    end
  end

  always_comb begin
    data_from_ram = '0;
    unique case (r_core_sel)
      SEL_RAM:  data_from_ram = w_ram_a_q;
      SEL_FWD:  data_from_ram = r_fwd_data;
      default:  data_from_ram = '0;
    endcase
  end

  always_comb begin
    vga_data = '0;
    unique case (r_vga_sel)
      SEL_RAM:  vga_data = w_ram_b_q;
      SEL_FWD:  vga_data = r_fwd_data;
      default:  vga_data = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Protection fault capture: sticky flag, first address wins.
  // --------------------------------------------------------------------------
  logic                 r_prot_fault;
  logic [RR_ADDR_W-1:0] r_fault_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prot_fault <= 1'b0;
      r_fault_addr <= '0;
    end else if (w_blocked) begin
      r_prot_fault <= 1'b1;
      if (!r_prot_fault) begin
        r_fault_addr <= ram_address;
      end
    end
  end

  assign prot_fault = r_prot_fault;
  assign fault_addr = r_fault_addr;

endmodule

// File: tb/tb_ram_responder.sv
// ----------------------------------------------------------------------------
// tb_ram_responder
//   Self-checking bench for ram_responder. A behavioural memory model
//   (array + "known" flags) predicts core and display read data, and the
//   sticky protection fault, from the externally visible rules.
// ----------------------------------------------------------------------------
module tb_ram_responder;

  localparam int FB_WORDS  = 19200;
  localparam int PROG_BASE = 19216;
  localparam int MEM_WORDS = 32768;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] ram_address;
  logic [15:0] data_to_ram;
  logic        web;
  logic [15:0] data_from_ram;
  logic [14:0] vga_address;
  logic [15:0] vga_data;
  logic        protect_en;
  logic        core_hold;
  logic        busy_clear;
  logic        prot_fault;
  logic [14:0] fault_addr;

  int vectors;
  int miscompares;

  // Reference model state
  logic [15:0] m_mem   [MEM_WORDS];
  bit          m_known [MEM_WORDS];
  logic        m_fault;
  logic [14:0] m_fault_addr;

  always #5 clk = ~clk;

  ram_responder dut (
    .clk           (clk),
    .rst           (rst),
    .ram_address   (ram_address),
    .data_to_ram   (data_to_ram),
    .web           (web),
    .data_from_ram (data_from_ram),
    .vga_address   (vga_address),
    .vga_data      (vga_data),
    .protect_en    (protect_en),
    .core_hold     (core_hold),
    .busy_clear    (busy_clear),
    .prot_fault    (prot_fault),
    .fault_addr    (fault_addr)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] rand_addr();
    logic [14:0] a;
    case ($urandom_range(0, 3))
      0:       a = 15'($urandom_range(0, FB_WORDS - 1));
      1:       a = 15'($urandom_range(19100, 19400));
      2:       a = 15'($urandom_range(95, 105));
      default: a = 15'($urandom_range(32700, 32767));
    endcase
    return a;
  endfunction

  // After a completed clear the whole framebuffer reads as zero.
  task automatic model_clear();
    for (int i = 0; i < FB_WORDS; i++) begin
      m_mem[i]   = 16'h0000;
      m_known[i] = 1'b1;
    end
  endtask

  // Called at a negedge; returns at the negedge after the reset edge.
  task automatic do_reset();
    web         = 1'b0;
    protect_en  = 1'b0;
    rst         = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst          = 1'b0;
    m_fault      = 1'b0;
    m_fault_addr = '0;
    check_val("rst_hold",  core_hold,     1);
    check_val("rst_busy",  busy_clear,    1);
    check_val("rst_dout",  data_from_ram, 0);
    check_val("rst_vga",   vga_data,      0);
    check_val("rst_fault", prot_fault,    0);
    check_val("rst_faddr", fault_addr,    0);
  endtask

  // Runs random traffic while core_hold is high; counts hold cycles.
  task automatic run_clear(input int limit, output int cycles);
    cycles = 0;
    while (core_hold === 1'b1 && cycles < limit) begin
      check_val("clr_busy",  busy_clear,    1);
      check_val("clr_dout",  data_from_ram, 0);
      check_val("clr_vga",   vga_data,      0);
      check_val("clr_fault", prot_fault,    0);
      if (cycles == 100) begin
        web = 1'b1; ram_address = 15'd19300; data_to_ram = 16'h5555;
        protect_en = 1'b1; vga_address = 15'd19300;
      end else begin
        web         = 1'($urandom);
        ram_address = rand_addr();
        data_to_ram = 16'($urandom);
        vga_address = rand_addr();
        protect_en  = 1'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    web        = 1'b0;
    protect_en = 1'b0;
  endtask

  // One RUN-phase transaction: drive at a negedge, sample at the next one.
  task automatic run_op(input logic w, input logic [14:0] a, input logic [15:0] d,
                        input logic [14:0] va, input logic pe);
    logic        blocked;
    logic [15:0] exp_core;
    logic [15:0] exp_vga;
    bit          core_k;
    bit          vga_k;
    web = w; ram_address = a; data_to_ram = d; vga_address = va; protect_en = pe;
    blocked = pe && w && (int'(a) >= PROG_BASE);
    if (w && !blocked) begin
      exp_core = d;        core_k = 1'b1;
    end else begin
      exp_core = m_mem[a]; core_k = m_known[a];
    end
    if (w && !blocked && va == a) begin
      exp_vga = d;          vga_k = 1'b1;
    end else begin
      exp_vga = m_mem[va];  vga_k = m_known[va];
    end
    if (blocked) begin
      if (!m_fault) m_fault_addr = a;
      m_fault = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    if (core_k) check_val("core_rd", data_from_ram, exp_core);
    if (vga_k)  check_val("vga_rd",  vga_data,      exp_vga);
    check_val("fault",      prot_fault, m_fault);
    check_val("fault_addr", fault_addr, m_fault_addr);
    check_val("run_hold",   core_hold,  0);
    if (w && !blocked) begin
      m_mem[a]   = d;
      m_known[a] = 1'b1;
    end
    $display("op web=%0d a=%0d d=%h va=%0d pe=%0d -> dout=%h vga=%h fault=%0d faddr=%0d",
             w, a, d, va, pe, data_from_ram, vga_data, prot_fault, fault_addr);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    web          = 1'b0;
    ram_address  = '0;
    data_to_ram  = '0;
    vga_address  = '0;
    protect_en   = 1'b0;
    m_fault      = 1'b0;
    m_fault_addr = '0;
    @(negedge clk);

    // First clear: full length, then the ports come alive.
    do_reset();
    run_clear(20000, n);
    check_val("clear_len_1", n, FB_WORDS);
    check_val("hold_after_1", core_hold, 0);
    model_clear();

    // Seed words inside and outside the framebuffer.
    run_op(1'b1, 15'd0,     16'hFFFF, 15'd0,     1'b0);
    run_op(1'b1, 15'd101,   16'hFFFF, 15'd101,   1'b0);
    run_op(1'b1, 15'd19199, 16'hFFFF, 15'd7,     1'b0);
    run_op(1'b1, 15'd19200, 16'hFFFF, 15'd19199, 1'b0);
    run_op(1'b1, 15'd19216, 16'h7777, 15'd19200, 1'b0);
    run_op(1'b1, 15'd19300, 16'h7777, 15'd19216, 1'b0);
    // Raise a fault so the next reset has something to clear.
    run_op(1'b1, 15'd19216, 16'hAAAA, 15'd19216, 1'b1);

    // Reset, then reset again mid-clear at clear_ptr = 5000.
    do_reset();
    run_clear(5000, n);
    check_val("partial_len", n, 5000);
    check_val("hold_mid", core_hold, 1);
    do_reset();
    run_clear(20000, n);
    check_val("clear_len_2", n, FB_WORDS);
    check_val("hold_after_2", core_hold, 0);
    model_clear();

    // Framebuffer edges cleared, words above it kept, clear-time write dropped.
    run_op(1'b0, 15'd0,     16'h0, 15'd19199, 1'b0);
    run_op(1'b0, 15'd19199, 16'h0, 15'd19200, 1'b0);
    run_op(1'b0, 15'd19200, 16'h0, 15'd19300, 1'b0);
    run_op(1'b0, 15'd19300, 16'h0, 15'd101,   1'b0);
    check_val("keep_19300", data_from_ram, 16'h7777);

    // Core write then read-back, and a neighbour read.
    run_op(1'b1, 15'd100, 16'h1234, 15'd3,   1'b0);
    check_val("wr_first_100", data_from_ram, 16'h1234);
    run_op(1'b0, 15'd100, 16'h0,    15'd100, 1'b0);
    run_op(1'b0, 15'd101, 16'h0,    15'd100, 1'b0);

    // Same-cycle core write and display read of one address.
    run_op(1'b1, 15'd500, 16'hBEEF, 15'd500, 1'b0);
    check_val("vga_fwd_500", vga_data, 16'hBEEF);

    // Protection: first fault address sticks; unprotected write succeeds.
    run_op(1'b1, 15'd19216, 16'hAAAA, 15'd19216, 1'b1);
    check_val("prot_old_data", vga_data, 16'h7777);
    run_op(1'b1, 15'd19300, 16'h1111, 15'd19300, 1'b1);
    run_op(1'b0, 15'd19216, 16'h0,    15'd19215, 1'b1);
    run_op(1'b1, 15'd19216, 16'hCAFE, 15'd19216, 1'b0);
    run_op(1'b0, 15'd19216, 16'h0,    15'd19300, 1'b1);
    check_val("fault_addr_first", fault_addr, 15'd19216);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic        w;
      logic [14:0] a;
      logic [14:0] va;
      w  = 1'($urandom);
      a  = rand_addr();
      va = ($urandom_range(0, 3) == 0) ? a : rand_addr();
      run_op(w, a, 16'($urandom), va, ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the core's RAM bus: accepts `ram_address`, `data_to_ram` and `web` from the core, and returns `data_from_ram` with a fixed 1-cycle latency.
- Provides a second, read-only port for the display scanner.
- After reset, zero-fills the framebuffer region and holds the core (driving its `debug_core` input) until the fill completes.
- Traps core writes into the program region when protection is enabled.

Parameters:
- DEPTH, 32768, words of backing store (15-bit address space).
- FB_WORDS, 19200, framebuffer size in words (80 words/line x 240 lines), cleared after reset.
- PROG_BASE, 19216, first word of the program region (core reset PC).
- DATA_W, 16, word width.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- ram_address, input, 15, core word address.
- data_to_ram, input, 16, core write data.
- web, input, 1, core write enable (1 = write).
- data_from_ram, output, 16, registered read data to the core.
- vga_address, input, 15, display read address.
- vga_data, output, 16, registered read data to the display.
- protect_en, input, 1, when 1, core writes at addresses >= PROG_BASE are blocked.
- core_hold, output, 1, connects to the core's `debug_core`; 1 while clearing.
- busy_clear, output, 1, 1 while in state CLEAR.
- prot_fault, output, 1, sticky flag set by a blocked write.
- fault_addr, output, 15, address of the first blocked write.

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values (registered outputs):
  - data_from_ram = 0, vga_data = 0.
  - prot_fault = 0, fault_addr = 0.
  - Next state = CLEAR, clear_ptr = 0.
  - core_hold and busy_clear are combinational from state, so both read 1 after reset.
- FSM: two states, CLEAR and RUN.
  - CLEAR: each cycle write 0 to mem[clear_ptr], then clear_ptr += 1.
  - When clear_ptr == FB_WORDS-1 that cycle, the final write happens and the state goes to RUN on the next edge. Clear takes exactly FB_WORDS cycles.
  - core_hold = busy_clear = (state == CLEAR).
  - During CLEAR:
    - Core writes are dropped; no fault is raised.
    - data_from_ram is registered as 0.
    - vga_data is registered as 0.
  - RUN is terminal until `rst`. Asserting `rst` at any point, including mid-clear, restarts CLEAR from clear_ptr = 0.
- Core port in RUN, latency 1: the value presented at edge N is visible after edge N+1.
  - Read (web = 0): data_from_ram <= mem[ram_address].
  - Write (web = 1) and allowed: mem[ram_address] <= data_to_ram, and data_from_ram <= data_to_ram (write-first).
  - Blocked write (protect_en = 1, ram_address >= PROG_BASE, web = 1):
    - Memory is unchanged.
    - data_from_ram <= old mem contents.
    - prot_fault <= 1.
    - fault_addr is latched only if prot_fault was 0; later faults do not overwrite it.
  - prot_fault clears only on `rst`.
- Display port in RUN: vga_data <= mem[vga_address] each cycle.
  - Simultaneous core write to the same address: vga_data returns the new data (forwarded).
  - A blocked write is not forwarded.
- Out-of-range addresses (>= DEPTH, only possible when DEPTH < 32768):
  - Writes are ignored.
  - Reads return 0.
  - Protection check still applies.
- Memory contents outside [0, FB_WORDS) survive reset (the program image stays loaded). Initial contents come from a load file via `$readmemh`, as a simulation/FPGA initial block.
- No back-pressure exists on either port. The core's fixed 1-cycle assumption must always hold in RUN.

Decomposition:
- Shared package/header holds:
  - FB_WORDS, PROG_BASE, and the address width 15.
  - The state encodings CLEAR/RUN.
  - The core opcode/state constants, so that the memory map lives in one place.
- One natural sub-module, `dp_ram_wf`:
  - Write port A with read-first raw output.
  - Read port B.
  - Both ports registered.
- `ram_responder` adds the clear FSM, protection, and forwarding muxes around `dp_ram_wf`.

Test Plan:
1. Assert `rst` for 1 cycle with mem preloaded to 0xFFFF -> core_hold = 1 for exactly 19200 cycles. Then mem[0] = mem[19199] = 0, mem[19200] = 0xFFFF, and vga_data stays 0 throughout CLEAR.
2. RUN, then write 0x1234 to address 100 and read address 100 on the next cycle -> data_from_ram = 0x1234 one cycle after each request. A following read of address 101 returns its preload value.
3. RUN, then core writes 0xBEEF to address 500 in the same cycle vga_address = 500 -> vga_data = 0xBEEF on the next cycle.
4. protect_en = 1:
   - Write 0xAAAA to address 19216 -> mem unchanged, prot_fault = 1, fault_addr = 19216.
   - A second blocked write to 19300 -> fault_addr stays 19216.
   - With protect_en = 0, a write to 19216 succeeds.
5. Assert `rst` at clear_ptr = 5000 mid-clear -> clear_ptr restarts at 0, CLEAR lasts a full 19200 cycles after reset, and prot_fault = 0.
6. During CLEAR, core write of 0x5555 to address 19300 -> ignored, prot_fault stays 0, data_from_ram = 0.
